// File: rtl/hazard_scoreboard.sv
// In-order pipeline hazard scoreboard: tracks in-flight destinations, raises load-use / RAW
// stalls and selects the youngest forwarding source for each decode operand.
`timescale 1ns/1ps
module hazard_scoreboard #(
    parameter int REG_ADDR_W = 4,
    parameter int PIPE_DEPTH = 3,
    parameter int LOAD_LAT   = 1,
    parameter int CNT_W      = 16,
    localparam int SEL_W     = $clog2(PIPE_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  forwarding_enable,
    input  logic                  id_valid,
    input  logic [1:0]            src_valid,
    input  logic [REG_ADDR_W-1:0] src0_addr,
    input  logic [REG_ADDR_W-1:0] src1_addr,
    input  logic                  id_wb_en,
    input  logic                  id_mem_r_en,
    input  logic [REG_ADDR_W-1:0] id_dest,
    input  logic                  flush,
    output logic                  stall,
    output logic [SEL_W-1:0]      fwd_sel0,
    output logic [SEL_W-1:0]      fwd_sel1,
    output logic [CNT_W-1:0]      stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [PIPE_DEPTH-1:0] valid_r;
    logic [PIPE_DEPTH-1:0] load_r;
    logic [REG_ADDR_W-1:0] dest_r [PIPE_DEPTH];
    logic [CNT_W-1:0]      stall_cnt_r;

    logic [REG_ADDR_W-1:0] src_addr_s [2];
    logic [SEL_W-1:0]      idx_s [2];
    logic [1:0]            haz_s;
    logic                  stall_s;
    logic                  push_s;

    function automatic logic src_match(input logic                  use_src,
                                       input logic                  ent_valid,
                                       input logic [REG_ADDR_W-1:0] addr,
                                       input logic [REG_ADDR_W-1:0] dest);
        return use_src & ent_valid & (addr == dest);
    endfunction

    assign src_addr_s[0] = src0_addr;
    assign src_addr_s[1] = src1_addr;

    // Youngest-match resolution: scan oldest to youngest so the lowest index wins.
    always_comb begin
        haz_s = 2'b00;
        for (int i = 0; i < 2; i++) begin
            idx_s[i] = {SEL_W{1'b0}};
            for (int k = PIPE_DEPTH - 1; k >= 0; k--) begin
                idx_s[i] = src_match(src_valid[i], valid_r[k], src_addr_s[i], dest_r[k])
                           ? SEL_W'(k + 1) : idx_s[i];
                haz_s[i] = src_match(src_valid[i], valid_r[k], src_addr_s[i], dest_r[k])
                           ? (forwarding_enable ? (load_r[k] & (k < LOAD_LAT)) : 1'b1)
                           : haz_s[i];
            end
        end
    end

    // Stall and forwarding selects; reset forces both quiet immediately.
    always_comb begin
        stall_s = rst & id_valid & ~flush & (|haz_s);
        push_s  = id_valid & ~stall_s & ~flush;
        if (rst && forwarding_enable && !stall_s) begin
            fwd_sel0 = idx_s[0];
            fwd_sel1 = idx_s[1];
        end else begin
            fwd_sel0 = {SEL_W{1'b0}};
            fwd_sel1 = {SEL_W{1'b0}};
        end
    end

    assign stall     = stall_s;
    assign stall_cnt = stall_cnt_r;

    // Scoreboard shift register; stalls and flushes insert a bubble at entry 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_r <= {PIPE_DEPTH{1'b0}};
            load_r  <= {PIPE_DEPTH{1'b0}};
            for (int k = 0; k < PIPE_DEPTH; k++) begin
                dest_r[k] <= {REG_ADDR_W{1'b0}};
            end
        end else begin
            for (int k = PIPE_DEPTH - 1; k >= 1; k--) begin
                valid_r[k] <= valid_r[k-1];
                load_r[k]  <= load_r[k-1];
                dest_r[k]  <= dest_r[k-1];
            end
            valid_r[0] <= push_s & id_wb_en;
            load_r[0]  <= push_s & id_mem_r_en;
            dest_r[0]  <= push_s ? id_dest : {REG_ADDR_W{1'b0}};
        end
    end

    // Saturating stalled-cycle counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_r <= {CNT_W{1'b0}};
        end else if (stall_s && (stall_cnt_r != CNT_MAX)) begin
            stall_cnt_r <= stall_cnt_r + CNT_ONE;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench: a driver pushes hand-computed per-cycle expectations, a negedge monitor pops and checks.
`timescale 1ns/1ps
module tb_hazard_scoreboard;

    typedef struct packed {
        logic        chk_fwd;
        logic        stall;
        logic [1:0]  f0;
        logic [1:0]  f1;
        logic [15:0] cnt;
        logic [1:0]  cnt2;
        logic [7:0]  step;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        forwarding_enable = 1'b0;
    logic        id_valid = 1'b0;
    logic [1:0]  src_valid = 2'b00;
    logic [3:0]  src0_addr = 4'd0;
    logic [3:0]  src1_addr = 4'd0;
    logic        id_wb_en = 1'b0;
    logic        id_mem_r_en = 1'b0;
    logic [3:0]  id_dest = 4'd0;
    logic        flush = 1'b0;

    logic        stall_a, stall_b;
    logic [1:0]  fwd0_a, fwd1_a, fwd0_b, fwd1_b;
    logic [15:0] cnt_a;
    logic [1:0]  cnt_b;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;
    int   step_no = 0;

    hazard_scoreboard u_dut (
        .clk(clk), .rst(rst), .forwarding_enable(forwarding_enable), .id_valid(id_valid),
        .src_valid(src_valid), .src0_addr(src0_addr), .src1_addr(src1_addr),
        .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest), .flush(flush),
        .stall(stall_a), .fwd_sel0(fwd0_a), .fwd_sel1(fwd1_a), .stall_cnt(cnt_a)
    );

    hazard_scoreboard #(.CNT_W(2)) u_dut_c2 (
        .clk(clk), .rst(rst), .forwarding_enable(forwarding_enable), .id_valid(id_valid),
        .src_valid(src_valid), .src0_addr(src0_addr), .src1_addr(src1_addr),
        .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .id_dest(id_dest), .flush(flush),
        .stall(stall_b), .fwd_sel0(fwd0_b), .fwd_sel1(fwd1_b), .stall_cnt(cnt_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] st, input logic [15:0] act,
                       input logic [15:0] req);
        n_checks++;
        if (act === req) begin
            n_pass++;
        end else begin
            $display("FAIL step %0d %s: got %0d expected %0d", st, nm, act, req);
        end
    endtask

    // Drive one cycle of inputs just after the rising edge and queue its expected outputs.
    task automatic cyc(input logic r, input logic fwd, input logic idv, input logic [1:0] sv,
                       input logic [3:0] s0, input logic [3:0] s1, input logic wb,
                       input logic ld, input logic [3:0] dst, input logic fl,
                       input logic e_stall, input logic [1:0] e_f0, input logic [1:0] e_f1,
                       input logic [15:0] e_cnt, input logic [1:0] e_cnt2, input logic chkf);
        exp_t e;
        @(posedge clk);
        #1;
        rst = r; forwarding_enable = fwd; id_valid = idv; src_valid = sv;
        src0_addr = s0; src1_addr = s1; id_wb_en = wb; id_mem_r_en = ld;
        id_dest = dst; flush = fl;
        step_no++;
        e.chk_fwd = chkf; e.stall = e_stall; e.f0 = e_f0; e.f1 = e_f1;
        e.cnt = e_cnt; e.cnt2 = e_cnt2; e.step = 8'(step_no);
        exp_q.push_back(e);
    endtask

    task automatic nop(input logic fwd, input logic [15:0] e_cnt, input logic [1:0] e_cnt2);
        cyc(1'b1, fwd, 1'b0, 2'b00, 4'd0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0,
            1'b0, 2'd0, 2'd0, e_cnt, e_cnt2, 1'b1);
    endtask

    // Monitor: compare outputs mid-cycle against the oldest queued expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("stall", e.step, 16'(stall_a), 16'(e.stall));
            chk("stall_cnt", e.step, cnt_a, e.cnt);
            chk("stall_cnt_w2", e.step, 16'(cnt_b), 16'(e.cnt2));
            if (e.chk_fwd) begin
                chk("fwd_sel0", e.step, 16'(fwd0_a), 16'(e.f0));
                chk("fwd_sel1", e.step, 16'(fwd1_a), 16'(e.f1));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state: no stall, no forwarding, counters clear
        cyc(1'b0, 1'b1, 1'b1, 2'b11, 4'd3, 4'd3, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 2'd0, 2'd0, 16'd0, 2'd0, 1'b1);
        // load-use with forwarding: LDR r3, then reader of r3
        cyc(1'b1, 1'b1, 1'b1, 2'b00, 4'd0, 4'd0, 1'b1, 1'b1, 4'd3, 1'b0, 1'b0, 2'd0, 2'd0, 16'd0, 2'd0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 2'b01, 4'd3, 4'd0, 1'b1, 1'b0, 4'd4, 1'b0, 1'b1, 2'd0, 2'd0, 16'd0, 2'd0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 2'b01, 4'd3, 4'd0, 1'b1, 1'b0, 4'd4, 1'b0, 1'b0, 2'd2, 2'd0, 16'd1, 2'd1, 1'b1);
        nop(1'b1, 16'd1, 2'd1); nop(1'b1, 16'd1, 2'd1); nop(1'b1, 16'd1, 2'd1);
        // youngest-first forwarding: ADD r2, SUB r2, reader walks through every stage
        cyc(1'b1, 1'b1, 1'b1, 2'b00, 4'd0, 4'd0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 2'd0, 2'd0, 16'd1, 2'd1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 2'b00, 4'd0, 4'd0, 1'b1, 1'b0, 4'd2, 1'b0, 1'b0, 2'd0, 2'd0, 16'd1, 2'd1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 2'b11, 4'd2, 4'd2, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd1, 2'd1, 16'd1, 2'd1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 2'b11, 4'd2, 4'd2, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd2, 2'd2, 16'd1, 2'd1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 2'b11, 4'd2, 4'd2, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd3, 2'd3, 16'd1, 2'd1, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 2'b11, 4'd2, 4'd2, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0, 2'd0, 16'd1, 2'd1, 1'b1);
        // forwarding off: ADD r5, reader on src1 only stalls three cycles
        cyc(1'b1, 1'b0, 1'b1, 2'b00, 4'd0, 4'd0, 1'b1, 1'b0, 4'd5, 1'b0, 1'b0, 2'd0, 2'd0, 16'd1, 2'd1, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 2'b10, 4'd5, 4'd5, 1'b1, 1'b0, 4'd6, 1'b0, 1'b1, 2'd0, 2'd0, 16'd1, 2'd1, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 2'b10, 4'd5, 4'd5, 1'b1, 1'b0, 4'd6, 1'b0, 1'b1, 2'd0, 2'd0, 16'd2, 2'd2, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 2'b10, 4'd5, 4'd5, 1'b1, 1'b0, 4'd6, 1'b0, 1'b1, 2'd0, 2'd0, 16'd3, 2'd3, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 2'b10, 4'd5, 4'd5, 1'b1, 1'b0, 4'd6, 1'b0, 1'b0, 2'd0, 2'd0, 16'd4, 2'd3, 1'b1);
        nop(1'b0, 16'd4, 2'd3); nop(1'b0, 16'd4, 2'd3); nop(1'b0, 16'd4, 2'd3);
        // flush beats load-use stall; entry 0 must be a bubble afterwards
        cyc(1'b1, 1'b1, 1'b1, 2'b00, 4'd0, 4'd0, 1'b1, 1'b1, 4'd7, 1'b0, 1'b0, 2'd0, 2'd0, 16'd4, 2'd3, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 2'b01, 4'd7, 4'd0, 1'b1, 1'b0, 4'd8, 1'b1, 1'b0, 2'd0, 2'd0, 16'd4, 2'd3, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 2'b11, 4'd7, 4'd8, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd2, 2'd0, 16'd4, 2'd3, 1'b1);
        nop(1'b1, 16'd4, 2'd3);
        // two more stalls (2-bit counter stays saturated), then reset mid-stall
        cyc(1'b1, 1'b0, 1'b1, 2'b00, 4'd0, 4'd0, 1'b1, 1'b0, 4'd9, 1'b0, 1'b0, 2'd0, 2'd0, 16'd4, 2'd3, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 2'b01, 4'd9, 4'd0, 1'b1, 1'b0, 4'd10, 1'b0, 1'b1, 2'd0, 2'd0, 16'd4, 2'd3, 1'b1);
        cyc(1'b1, 1'b0, 1'b1, 2'b01, 4'd9, 4'd0, 1'b1, 1'b0, 4'd10, 1'b0, 1'b1, 2'd0, 2'd0, 16'd5, 2'd3, 1'b1);
        cyc(1'b0, 1'b0, 1'b1, 2'b01, 4'd9, 4'd0, 1'b1, 1'b0, 4'd10, 1'b0, 1'b0, 2'd0, 2'd0, 16'd0, 2'd0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 2'b01, 4'd9, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd0, 2'd0, 16'd0, 2'd0, 1'b1);
        // forwarding toggle takes effect immediately on unchanged contents
        cyc(1'b1, 1'b1, 1'b1, 2'b00, 4'd0, 4'd0, 1'b1, 1'b1, 4'd11, 1'b0, 1'b0, 2'd0, 2'd0, 16'd0, 2'd0, 1'b1);
        nop(1'b1, 16'd0, 2'd0);
        cyc(1'b1, 1'b0, 1'b1, 2'b01, 4'd11, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 2'd0, 2'd0, 16'd0, 2'd0, 1'b1);
        cyc(1'b1, 1'b1, 1'b1, 2'b01, 4'd11, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 2'd3, 2'd0, 16'd1, 2'd1, 1'b1);
        nop(1'b1, 16'd1, 2'd1);
        @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_pass++;
        end else begin
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
